// File: rtl/dcache_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_ctrl
// Direct-mapped, write-back, write-allocate data cache controller sitting in
// front of a 256-word line memory (4 x 32-bit words per 128-bit line).
//
// Ports
//   clk            system clock
//   rst            asynchronous, active-low reset
//   cpu_req_addr   8-bit word address {tag, index, word offset}
//   cpu_req_rw     1 = store, 0 = load
//   cpu_req_valid  request strobe (only looked at in IDLE)
//   cpu_data_write store data
//   cpu_data_read  load data, valid while cpu_ready = 1
//   cpu_ready      one-cycle completion pulse
//   mem_req_addr   line base word address (bits [1:0] always 0)
//   mem_req_rw     1 = line write-back, 0 = line fill
//   mem_req_valid  one-cycle memory request strobe
//   mem_data_write victim line for write-back
//   mem_data_read  fill line from memory
//   mem_ready      memory completion
//   hit_count      (DCACHE_STATS_EN only) saturating hit counter
//   miss_count     (DCACHE_STATS_EN only) saturating miss counter
//
// Optional feature macro: DCACHE_STATS_EN adds hit/miss counters.
// ---------------------------------------------------------------------------
module dcache_ctrl #(
    parameter int INDEX_BITS = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   cpu_req_addr,
    input  logic         cpu_req_rw,
    input  logic         cpu_req_valid,
    input  logic [31:0]  cpu_data_write,
    output logic [31:0]  cpu_data_read,
    output logic         cpu_ready,
    output logic [7:0]   mem_req_addr,
    output logic         mem_req_rw,
    output logic         mem_req_valid,
    output logic [127:0] mem_data_write,
    input  logic [127:0] mem_data_read,
    input  logic         mem_ready
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
`endif
);

    localparam int NLINES   = 1 << INDEX_BITS;
    localparam int TAG_BITS = 6 - INDEX_BITS;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WB_REQ,
        WB_WAIT,
        ALLOC_REQ,
        ALLOC_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          addr_q, addr_d;
    logic                rw_q, rw_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [NLINES-1:0]   valid_q, valid_d;
    logic [NLINES-1:0]   dirty_q, dirty_d;
    logic                cpu_ready_q, cpu_ready_d;
    logic [31:0]         cpu_data_read_q, cpu_data_read_d;
    logic                mem_req_valid_q, mem_req_valid_d;
    logic                mem_req_rw_q, mem_req_rw_d;
    logic [7:0]          mem_req_addr_q, mem_req_addr_d;
    logic [127:0]        mem_data_write_q, mem_data_write_d;

    // Tag and data storage: no reset, only the valid/dirty bits are cleared.
    logic [TAG_BITS-1:0] tag_q  [NLINES];
    logic [127:0]        data_q [NLINES];

    logic                data_we;
    logic                tag_we;
    logic [127:0]        line_wdata;

    // Fields of the latched request.
    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] req_index;
    logic [1:0]            req_offset;
    logic [127:0]          cur_line;
    logic [TAG_BITS-1:0]   cur_tag;
    logic                  hit;
    logic [127:0]          merged_line;

    assign req_tag    = addr_q[7:2+INDEX_BITS];
    assign req_index  = addr_q[1+INDEX_BITS:2];
    assign req_offset = addr_q[1:0];
    assign cur_line   = data_q[req_index];
    assign cur_tag    = tag_q[req_index];
    assign hit        = valid_q[req_index] && (cur_tag == req_tag);

    // Current line with the addressed word replaced by the store data.
    always_comb begin
        merged_line = cur_line;
        merged_line[{req_offset, 5'b00000} +: 32] = wdata_q;
    end

`ifdef DCACHE_STATS_EN
    // first_q marks the first COMPARE of a request so the post-refill
    // COMPARE is not counted twice.
    logic        first_q, first_d;
    logic [15:0] hit_count_q, hit_count_d;
    logic [15:0] miss_count_q, miss_count_d;
`endif

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        rw_d             = rw_q;
        wdata_d          = wdata_q;
        valid_d          = valid_q;
        dirty_d          = dirty_q;
        cpu_ready_d      = 1'b0;
        cpu_data_read_d  = cpu_data_read_q;
        mem_req_valid_d  = 1'b0;
        mem_req_rw_d     = mem_req_rw_q;
        mem_req_addr_d   = mem_req_addr_q;
        mem_data_write_d = mem_data_write_q;
        data_we          = 1'b0;
        tag_we           = 1'b0;
        line_wdata       = mem_data_read;
`ifdef DCACHE_STATS_EN
        first_d          = first_q;
        hit_count_d      = hit_count_q;
        miss_count_d     = miss_count_q;
`endif

        unique case (state_q)
            IDLE: begin
                // cpu_ready_q high means a response is on the bus this cycle;
                // this enforces the single bubble between requests.
                if (cpu_req_valid && !cpu_ready_q) begin
                    addr_d  = cpu_req_addr;
                    rw_d    = cpu_req_rw;
                    wdata_d = cpu_data_write;
                    state_d = COMPARE;
`ifdef DCACHE_STATS_EN
                    first_d = 1'b1;
`endif
                end
            end

            COMPARE: begin
`ifdef DCACHE_STATS_EN
                first_d = 1'b0;
                if (first_q) begin
                    if (hit) begin
                        if (hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
                    end else begin
                        if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
                    end
                end
`endif
                if (hit) begin
                    cpu_ready_d = 1'b1;
                    state_d     = IDLE;
                    if (rw_q) begin
                        data_we            = 1'b1;
                        line_wdata         = merged_line;
                        dirty_d[req_index] = 1'b1;
                    end else begin
                        cpu_data_read_d = cur_line[{req_offset, 5'b00000} +: 32];
                    end
                end else if (valid_q[req_index] && dirty_q[req_index]) begin
                    state_d          = WB_REQ;
                    mem_req_valid_d  = 1'b1;
                    mem_req_rw_d     = 1'b1;
                    mem_req_addr_d   = {cur_tag, req_index, 2'b00};
                    mem_data_write_d = cur_line;
                end else begin
                    state_d         = ALLOC_REQ;
                    mem_req_valid_d = 1'b1;
                    mem_req_rw_d    = 1'b0;
                    mem_req_addr_d  = {req_tag, req_index, 2'b00};
                end
            end

            WB_REQ: begin
                state_d = WB_WAIT;
            end

            WB_WAIT: begin
                // The fill request is raised one cycle after mem_ready is
                // consumed, so this completion cannot be mistaken for the
                // fill's completion.
                if (mem_ready) begin
                    state_d         = ALLOC_REQ;
                    mem_req_valid_d = 1'b1;
                    mem_req_rw_d    = 1'b0;
                    mem_req_addr_d  = {req_tag, req_index, 2'b00};
                end
            end

            ALLOC_REQ: begin
                state_d = ALLOC_WAIT;
            end

            ALLOC_WAIT: begin
                if (mem_ready) begin
                    data_we            = 1'b1;
                    tag_we             = 1'b1;
                    line_wdata         = mem_data_read;
                    valid_d[req_index] = 1'b1;
                    dirty_d[req_index] = 1'b0;
                    state_d            = COMPARE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            addr_q           <= '0;
            rw_q             <= 1'b0;
            wdata_q          <= '0;
            valid_q          <= '0;
            dirty_q          <= '0;
            cpu_ready_q      <= 1'b0;
            cpu_data_read_q  <= '0;
            mem_req_valid_q  <= 1'b0;
            mem_req_rw_q     <= 1'b0;
            mem_req_addr_q   <= '0;
            mem_data_write_q <= '0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            rw_q             <= rw_d;
            wdata_q          <= wdata_d;
            valid_q          <= valid_d;
            dirty_q          <= dirty_d;
            cpu_ready_q      <= cpu_ready_d;
            cpu_data_read_q  <= cpu_data_read_d;
            mem_req_valid_q  <= mem_req_valid_d;
            mem_req_rw_q     <= mem_req_rw_d;
            mem_req_addr_q   <= mem_req_addr_d;
            mem_data_write_q <= mem_data_write_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) data_q[req_index] <= line_wdata;
        if (tag_we)  tag_q[req_index]  <= req_tag;
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_q      <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            first_q      <= first_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

    assign cpu_ready      = cpu_ready_q;
    assign cpu_data_read  = cpu_data_read_q;
    assign mem_req_valid  = mem_req_valid_q;
    assign mem_req_rw     = mem_req_rw_q;
    assign mem_req_addr   = mem_req_addr_q;
    assign mem_data_write = mem_data_write_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dcache_ctrl
// Self-checking bench for dcache_ctrl (INDEX_BITS = 2). A zero-filled line
// memory model answers every request with mem_ready one cycle later. Expected
// memory requests are queued by each scenario before its CPU request and are
// popped and compared by a monitor as the DUT issues them. CPU latency and
// load data are compared inline in each scenario task.
// ---------------------------------------------------------------------------
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   cpu_req_addr;
    logic         cpu_req_rw;
    logic         cpu_req_valid;
    logic [31:0]  cpu_data_write;
    logic [31:0]  cpu_data_read;
    logic         cpu_ready;
    logic [7:0]   mem_req_addr;
    logic         mem_req_rw;
    logic         mem_req_valid;
    logic [127:0] mem_data_write;
    logic [127:0] mem_data_read = '0;
    logic         mem_ready = 1'b0;
`ifdef DCACHE_STATS_EN
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic         rw;
        logic [7:0]   addr;
        logic [127:0] data;
    } mreq_t;

    mreq_t exp_mem_q[$];

    logic [127:0] mem_model [64];

    always #5 clk = ~clk;

    dcache_ctrl #(.INDEX_BITS(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_rw     (cpu_req_rw),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_data_write (cpu_data_write),
        .cpu_data_read  (cpu_data_read),
        .cpu_ready      (cpu_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_rw     (mem_req_rw),
        .mem_req_valid  (mem_req_valid),
        .mem_data_write (mem_data_write),
        .mem_data_read  (mem_data_read),
        .mem_ready      (mem_ready)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    // Line memory model: one-cycle response to every request.
    always @(posedge clk) begin
        mem_ready <= 1'b0;
        if (mem_req_valid) begin
            if (mem_req_rw) mem_model[mem_req_addr[7:2]] <= mem_data_write;
            else            mem_data_read <= mem_model[mem_req_addr[7:2]];
            mem_ready <= 1'b1;
        end
    end

    // Scoreboard monitor: every issued request must match the next expected one.
    always @(negedge clk) begin
        if (rst === 1'b1 && mem_req_valid === 1'b1) begin
            n_checks++;
            if (exp_mem_q.size() == 0) begin
                n_fail++;
                $display("FAIL mem_req_unexpected: got rw=%0b addr=%02h, required none", mem_req_rw, mem_req_addr);
            end else begin
                mreq_t e;
                e = exp_mem_q.pop_front();
                if (mem_req_rw !== e.rw || mem_req_addr !== e.addr ||
                    (e.rw && mem_data_write !== e.data)) begin
                    n_fail++;
                    $display("FAIL mem_req: got rw=%0b addr=%02h data=%032h, required rw=%0b addr=%02h data=%032h",
                             mem_req_rw, mem_req_addr, mem_data_write, e.rw, e.addr, e.data);
                end else begin
                    $display("mem_req rw=%0b addr=%02h data=%032h ok", mem_req_rw, mem_req_addr, mem_data_write);
                end
            end
        end
    end

    function automatic mreq_t mk(input logic rw, input logic [7:0] a, input logic [127:0] d);
        mreq_t r;
        r.rw = rw; r.addr = a; r.data = d;
        return r;
    endfunction

    // Drives one request and measures latency in cycles from acceptance.
    // lat = -1 when no cpu_ready arrives within the budget.
    task automatic run_req(input logic rw, input logic [7:0] a, input logic [31:0] wd,
                           output int lat, output logic [31:0] rd);
        lat = -1;
        rd  = 'x;
        @(negedge clk);
        cpu_req_valid  = 1'b1;
        cpu_req_rw     = rw;
        cpu_req_addr   = a;
        cpu_data_write = wd;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (c > 1) @(negedge clk);
            if (cpu_ready === 1'b1) begin
                lat = c;
                rd  = cpu_data_read;
                break;
            end
        end
        $display("cpu_req rw=%0b addr=%02h wdata=%08h -> latency=%0d rdata=%08h", rw, a, wd, lat, rd);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        cpu_req_valid = 1'b0; cpu_req_rw = 1'b0; cpu_req_addr = '0; cpu_data_write = '0;
        for (int i = 0; i < 64; i++) mem_model[i] = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (cpu_ready !== 1'b0 || cpu_data_read !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_cpu_out: got ready=%0b data=%08h, required 0/0", cpu_ready, cpu_data_read);
        end
        n_checks++;
        if (mem_req_valid !== 1'b0 || mem_req_rw !== 1'b0 || mem_req_addr !== 8'h0 || mem_data_write !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_mem_out: got valid=%0b rw=%0b addr=%02h data=%032h, required all 0",
                     mem_req_valid, mem_req_rw, mem_req_addr, mem_data_write);
        end
        rst = 1'b1;
        $display("reset released");
    endtask

    task automatic test_clean_miss;
        int lat; logic [31:0] rd;
        exp_mem_q.push_back(mk(1'b0, 8'h04, '0));
        run_req(1'b0, 8'h05, 32'h0, lat, rd);
        n_checks++;
        if (lat !== 5) begin n_fail++; $display("FAIL clean_miss_latency: got %0d, required 5", lat); end
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL clean_miss_data: got %08h, required 00000000", rd); end
        n_checks++;
        if (exp_mem_q.size() != 0) begin n_fail++; $display("FAIL clean_miss_reqs: %0d expected requests not issued, required 0", exp_mem_q.size()); exp_mem_q.delete(); end
    endtask

    task automatic test_store_hit;
        int lat; logic [31:0] rd;
        run_req(1'b1, 8'h05, 32'hDEADBEEF, lat, rd);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL store_hit_latency: got %0d, required 2", lat); end
        run_req(1'b0, 8'h05, 32'h0, lat, rd);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL load_hit_latency: got %0d, required 2", lat); end
        n_checks++;
        if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_hit_data: got %08h, required deadbeef", rd); end
    endtask

    task automatic test_dirty_miss;
        int lat; logic [31:0] rd;
        exp_mem_q.push_back(mk(1'b1, 8'h04, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}));
        exp_mem_q.push_back(mk(1'b0, 8'h44, '0));
        run_req(1'b0, 8'h45, 32'h0, lat, rd);
        n_checks++;
        if (lat !== 7) begin n_fail++; $display("FAIL dirty_miss_latency: got %0d, required 7", lat); end
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL dirty_miss_data: got %08h, required 00000000", rd); end
        n_checks++;
        if (exp_mem_q.size() != 0) begin n_fail++; $display("FAIL dirty_miss_reqs: %0d expected requests not issued, required 0", exp_mem_q.size()); exp_mem_q.delete(); end
    endtask

    task automatic test_refetch;
        int lat; logic [31:0] rd;
        exp_mem_q.push_back(mk(1'b0, 8'h04, '0));
        run_req(1'b0, 8'h05, 32'h0, lat, rd);
        n_checks++;
        if (lat !== 5) begin n_fail++; $display("FAIL refetch_latency: got %0d, required 5", lat); end
        n_checks++;
        if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL refetch_data: got %08h, required deadbeef", rd); end
        n_checks++;
        if (exp_mem_q.size() != 0) begin n_fail++; $display("FAIL refetch_reqs: %0d expected requests not issued, required 0", exp_mem_q.size()); exp_mem_q.delete(); end
`ifdef DCACHE_STATS_EN
        n_checks++;
        if (hit_count !== 16'd2 || miss_count !== 16'd3) begin
            n_fail++;
            $display("FAIL stats: got hit=%0d miss=%0d, required hit=2 miss=3", hit_count, miss_count);
        end
`endif
    endtask

    task automatic test_back_to_back;
        int lat; logic [31:0] rd;
        exp_mem_q.push_back(mk(1'b0, 8'h08, '0));
        run_req(1'b1, 8'h0A, 32'h12345678, lat, rd);
        n_checks++;
        if (lat !== 5) begin n_fail++; $display("FAIL store_miss_latency: got %0d, required 5", lat); end
        run_req(1'b0, 8'h0A, 32'h0, lat, rd);
        n_checks++;
        if (lat !== 2 || rd !== 32'h12345678) begin n_fail++; $display("FAIL store_miss_readback: got lat=%0d data=%08h, required lat=2 data=12345678", lat, rd); end
        run_req(1'b0, 8'h0B, 32'h0, lat, rd);
        n_checks++;
        if (lat !== 2 || rd !== 32'h0) begin n_fail++; $display("FAIL same_line_word3: got lat=%0d data=%08h, required lat=2 data=00000000", lat, rd); end
        n_checks++;
        if (exp_mem_q.size() != 0) begin n_fail++; $display("FAIL back_to_back_reqs: %0d expected requests not issued, required 0", exp_mem_q.size()); exp_mem_q.delete(); end
    endtask

    task automatic test_reset_mid;
        int lat; logic [31:0] rd;
        run_req(1'b1, 8'h05, 32'hCAFEF00D, lat, rd);
        run_req(1'b0, 8'h05, 32'h0, lat, rd);
        n_checks++;
        if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL pre_reset_load: got %08h, required cafef00d", rd); end
        // Dirty miss on index 1; reset lands in WB_WAIT (cycle 3).
        exp_mem_q.push_back(mk(1'b1, 8'h04, {32'h0, 32'h0, 32'hCAFEF00D, 32'h0}));
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_rw = 1'b0; cpu_req_addr = 8'h45; cpu_data_write = 32'h0;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (mem_req_valid !== 1'b0 || mem_req_rw !== 1'b0 || mem_req_addr !== 8'h0 || mem_data_write !== 128'h0 ||
            cpu_ready !== 1'b0 || cpu_data_read !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got mvalid=%0b rw=%0b addr=%02h data=%032h ready=%0b rdata=%08h, required all 0",
                     mem_req_valid, mem_req_rw, mem_req_addr, mem_data_write, cpu_ready, cpu_data_read);
        end
        n_checks++;
        if (exp_mem_q.size() != 0) begin n_fail++; $display("FAIL mid_reset_wb: %0d expected requests not issued, required 0", exp_mem_q.size()); exp_mem_q.delete(); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        $display("mid-operation reset released");
        exp_mem_q.push_back(mk(1'b0, 8'h44, '0));
        run_req(1'b0, 8'h45, 32'h0, lat, rd);
        n_checks++;
        if (lat !== 5 || rd !== 32'h0) begin n_fail++; $display("FAIL post_reset_miss: got lat=%0d data=%08h, required lat=5 data=00000000", lat, rd); end
        // Index 2 held dirty 12345678 before reset; it must now miss and refill 0.
        exp_mem_q.push_back(mk(1'b0, 8'h08, '0));
        run_req(1'b0, 8'h0A, 32'h0, lat, rd);
        n_checks++;
        if (lat !== 5 || rd !== 32'h0) begin n_fail++; $display("FAIL post_reset_invalid: got lat=%0d data=%08h, required lat=5 data=00000000", lat, rd); end
        n_checks++;
        if (exp_mem_q.size() != 0) begin n_fail++; $display("FAIL post_reset_reqs: %0d expected requests not issued, required 0", exp_mem_q.size()); exp_mem_q.delete(); end
`ifdef DCACHE_STATS_EN
        n_checks++;
        if (hit_count !== 16'd0 || miss_count !== 16'd2) begin
            n_fail++;
            $display("FAIL post_reset_stats: got hit=%0d miss=%0d, required hit=0 miss=2", hit_count, miss_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_clean_miss();
        test_store_hit();
        test_dirty_miss();
        test_refetch();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
